// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
//   Bundles the requester ports (I fetch, D load/store) and the shared memory
//   port that mem_bus_arbiter sits between.
//
//   Signals
//     i_req/i_addr                     I port request (read-only port)
//     i_done/i_rdata                   I port completion pulse and read data
//     d_req/d_addr/d_we/d_wdata/d_wstrb D port request
//     d_done/d_rdata/d_err             D port completion, read data, timeout flag
//     mem_valid/mem_addr/mem_we/
//     mem_wdata/mem_wstrb              shared memory request
//     mem_ready/mem_rdata              memory completion and read data
//
//   Modports
//     master  arbiter view: it serves the requesters and masters the memory port
//     slave   view of everything around the arbiter (requesters plus memory)
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 64
);
    logic              i_req;
    logic [AW-1:0]     i_addr;
    logic              i_done;
    logic [DW-1:0]     i_rdata;

    logic              d_req;
    logic [AW-1:0]     d_addr;
    logic              d_we;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_wstrb;
    logic              d_done;
    logic [DW-1:0]     d_rdata;
    logic              d_err;

    logic              mem_valid;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_wstrb;
    logic              mem_ready;
    logic [DW-1:0]     mem_rdata;

    modport master (
        input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, d_wstrb, mem_ready, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata, d_err,
        output mem_valid, mem_addr, mem_we, mem_wdata, mem_wstrb
    );

    modport slave (
        output i_req, i_addr, d_req, d_addr, d_we, d_wdata, d_wstrb, mem_ready, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata, d_err,
        input  mem_valid, mem_addr, mem_we, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one memory port between the CPU instruction-fetch port (I) and the
//   load/store port (D). One transaction in flight; the winner's request fields
//   are latched at grant and drive the memory port until mem_ready (or timeout).
//   Completion returns to the owner as a registered one-cycle done pulse.
//
//   Ports
//     clk    system clock, all logic on posedge
//     reset  synchronous, active-high
//     bus    mem_bus_arbiter_if.master (requester and memory signals)
//
//   Parameters
//     AW       address width
//     DW       data width (DW/8 byte strobes)
//     TIMEOUT  consecutive mem_valid cycles without mem_ready before the access
//              is abandoned (0 disables)
//
//   Build option
//     ARB_ROUND_ROBIN_EN  defined: ties go to the port that did not own the bus
//                         last. Undefined: D always wins ties.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned AW      = 64,
    parameter int unsigned DW      = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.master bus
);
    localparam int unsigned SW = DW / 8;
    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {StIdle, StOwnI, StOwnD} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            i_done_q, i_done_d;
    logic            d_done_q, d_done_d;
    logic            d_err_q, d_err_d;
    logic [DW-1:0]   i_rdata_q, i_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            grant_i, grant_d;
    logic            timeout_hit;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when D owned the bus most recently; resets to I so D takes the first tie.
    logic last_d_q, last_d_d;

    assign grant_d = bus.d_req && (!bus.i_req || !last_d_q);
`else
    assign grant_d = bus.d_req;
`endif
    assign grant_i = bus.i_req && !grant_d;

    // Fires in the TIMEOUT-th consecutive owned cycle without mem_ready.
    assign timeout_hit = (TIMEOUT != 0) && !bus.mem_ready && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        cnt_d     = cnt_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        d_err_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_d  = last_d_q;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (grant_d) begin
                    state_d = StOwnD;
                    addr_d  = bus.d_addr;
                    we_d    = bus.d_we;
                    wdata_d = bus.d_wdata;
                    wstrb_d = bus.d_we ? bus.d_wstrb : '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b1;
`endif
                end else if (grant_i) begin
                    state_d = StOwnI;
                    addr_d  = bus.i_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    wstrb_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b0;
`endif
                end
            end
            StOwnI, StOwnD: begin
                if (bus.mem_ready) begin
                    state_d = StIdle;
                    if (state_q == StOwnI) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = bus.mem_rdata;
                    end else begin
                        d_done_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end
                end else if (timeout_hit) begin
                    // Abandon the access; the owner still gets its done pulse.
                    state_d = StIdle;
                    if (state_q == StOwnI) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = '0;
                    end else begin
                        d_done_d  = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            cnt_q     <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            d_err_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            cnt_q     <= cnt_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            d_err_q   <= d_err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q  <= last_d_d;
`endif
        end
    end

    assign bus.mem_valid = (state_q != StIdle);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.i_done    = i_done_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
endmodule
